// File: rtl/pc_gen_pkg.sv
// Shared fetch-stage definitions: next-PC select codes, exception codes
// and the default memory-map constants used across the pipeline.
package pc_gen_pkg;

    typedef enum logic [2:0] {
        NPC_PC4   = 3'd0,
        NPC_IMM16 = 3'd1,
        NPC_IMM26 = 3'd2,
        NPC_RA    = 3'd3,
        NPC_EPC   = 3'd4
    } npc_op_e;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] DEF_IM_LO      = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_HI      = 32'h0000_6FFC;
    localparam int          DEF_RAS_DEPTH  = 8;

    function automatic logic [31:0] branch_target(
        input logic [31:0] pc,
        input logic [15:0] imm
    );
        return pc + {{14{imm[15]}}, imm, 2'b00};
    endfunction

    function automatic logic [31:0] jump_target(
        input logic [31:0] pc_hi,
        input logic [25:0] idx
    );
        return {pc_hi[31:28], idx, 2'b00};
    endfunction

    // Misaligned or outside the instruction window.
    function automatic logic fetch_adel(
        input logic [31:0] pc,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
    endfunction

endpackage

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest
// entry, a pop when empty is ignored. Entry storage is never reset.
module ras_stack
    import pc_gen_pkg::*;
#(
    parameter int DEPTH = DEF_RAS_DEPTH,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             data_in,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_ptr;
    logic [PW:0]   r_count;
    logic [PW-1:0] w_top_idx;
    logic          w_pop_ok;

    assign w_top_idx = r_ptr - PW'(1);
    assign w_pop_ok  = pop & (r_count != '0);

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            r_mem[r_ptr] <= data_in;
        end
    end

    // r_ptr is the next free slot; the wrap gives overwrite-oldest.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (push) begin
            r_ptr <= r_ptr + PW'(1);
            if (r_count != FULL) begin
                r_count <= r_count + 1'b1;
            end
        end else if (w_pop_ok) begin
            r_ptr   <= w_top_idx;
            r_count <= r_count - 1'b1;
        end
    end

    assign top   = r_mem[w_top_idx];
    assign count = r_count;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with exception redirect, fetch-address check and an
// advisory return-address stack for jal / jr $ra prediction.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] HANDLER_PC = DEF_HANDLER_PC,
    parameter logic [31:0] IM_LO      = DEF_IM_LO,
    parameter logic [31:0] IM_HI      = DEF_IM_HI,
    parameter int          RAS_DEPTH  = DEF_RAS_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         req,
    input  logic [2:0]                   npc_op,
    input  logic [15:0]                  imm16,
    input  logic [25:0]                  imm26,
    input  logic [31:0]                  ra_addr,
    input  logic [31:0]                  epc,
    input  logic [31:0]                  pc_d,
    input  logic                         push_ra,
    input  logic                         pop_ra,
    output logic [31:0]                  pc_f,
    output logic [31:0]                  pc4_f,
    output logic [31:0]                  npc,
    output logic [4:0]                   excode_f,
    output logic [31:0]                  ras_pred,
    output logic                         ras_match,
    output logic [$clog2(RAS_DEPTH):0]   ras_count
);

    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic [31:0]   r_pc;
    logic [31:0]   w_npc;
    logic [31:0]   w_pc4;
    logic          w_load;
    logic          w_fire;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_top;
    logic [CW-1:0] w_count;

    assign w_pc4 = r_pc + 32'd4;

    always_comb begin
        w_npc = RESET_PC;
        if (req) begin
            w_npc = HANDLER_PC;
        end else begin
            case (npc_op)
                NPC_PC4:   w_npc = w_pc4;
                NPC_IMM16: w_npc = branch_target(r_pc, imm16);
                NPC_IMM26: w_npc = jump_target(pc_d, imm26);
                NPC_RA:    w_npc = ra_addr;
                NPC_EPC:   w_npc = epc;
                default:   w_npc = RESET_PC;
            endcase
        end
    end

    // eret must leave even under a stall, or the handler would spin.
    assign w_load = req | ~stall | (npc_op == NPC_EPC);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (w_load) begin
            r_pc <= w_npc;
        end
    end

    assign w_fire = ~req & ~stall;
    assign w_push = w_fire & (npc_op == NPC_IMM26) & push_ra;
    assign w_pop  = w_fire & (npc_op == NPC_RA) & pop_ra;

    ras_stack #(
        .DEPTH   (RAS_DEPTH),
        .W       (32)
    ) u_ras (
        .clk     (clk),
        .reset   (reset),
        .push    (w_push),
        .pop     (w_pop),
        .data_in (pc_d + 32'd8),
        .top     (w_top),
        .count   (w_count)
    );

    assign pc_f      = r_pc;
    assign pc4_f     = w_pc4;
    assign npc       = w_npc;
    assign excode_f  = fetch_adel(r_pc, IM_LO, IM_HI) ? EXC_ADEL : EXC_NONE;
    assign ras_pred  = w_top;
    assign ras_count = w_count;
    assign ras_match = (w_count != '0) & (npc_op == NPC_RA) & pop_ra
                     & (w_top == ra_addr);

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: directed scenarios then random traffic,
// checked against a queue-based reference model.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset, stall, req, push_ra, pop_ra;
    logic [2:0]  npc_op;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] ra_addr, epc, pc_d;
    logic [31:0] pc_f, pc4_f, npc, ras_pred;
    logic [4:0]  excode_f;
    logic        ras_match;
    logic [3:0]  ras_count;

    always #5 clk = ~clk;

    pc_gen dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .req       (req),
        .npc_op    (npc_op),
        .imm16     (imm16),
        .imm26     (imm26),
        .ra_addr   (ra_addr),
        .epc       (epc),
        .pc_d      (pc_d),
        .push_ra   (push_ra),
        .pop_ra    (pop_ra),
        .pc_f      (pc_f),
        .pc4_f     (pc4_f),
        .npc       (npc),
        .excode_f  (excode_f),
        .ras_pred  (ras_pred),
        .ras_match (ras_match),
        .ras_count (ras_count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] npc;
        logic [4:0]  exc;
        logic [3:0]  cnt;
        logic        pred_v;
        logic [31:0] pred;
        logic        match;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          n_chk = 0;

    function automatic logic [31:0] m_next();
        if (req) return 32'h0000_4180;
        case (npc_op)
            3'd0: return m_pc + 32'd4;
            3'd1: return m_pc + {{16{imm16[15]}}, imm16} * 32'd4;
            3'd2: return {pc_d[31:28], imm26, 2'b00};
            3'd3: return ra_addr;
            3'd4: return epc;
            default: return 32'h0000_3000;
        endcase
    endfunction

    function automatic logic m_bad_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        reset = 0; stall = 0; req = 0; npc_op = 3'd0;
        push_ra = 0; pop_ra = 0;
    endtask

    // Record this cycle's expectation, advance the model, cross the edge.
    task automatic apply();
        exp_t        e;
        logic [31:0] n;
        bit          go;
        n = m_next();
        e.pc     = m_pc;
        e.pc4    = m_pc + 32'd4;
        e.npc    = n;
        e.exc    = m_bad_addr(m_pc) ? 5'd4 : 5'd0;
        e.cnt    = 4'(m_ras.size());
        e.pred_v = m_ras.size() > 0;
        e.pred   = e.pred_v ? m_ras[$] : 32'h0;
        e.match  = e.pred_v && npc_op == 3'd3 && pop_ra && m_ras[$] == ra_addr;
        sb.push_back(e);
        go = !req && !stall;
        if (reset) begin
            m_pc = 32'h0000_3000;
            m_ras.delete();
        end else begin
            if (req || !stall || npc_op == 3'd4) m_pc = n;
            if (go && npc_op == 3'd2 && push_ra) begin
                m_ras.push_back(pc_d + 32'd8);
                if (m_ras.size() > 8) void'(m_ras.pop_front());
            end else if (go && npc_op == 3'd3 && pop_ra && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            chk("pc_f", pc_f, e.pc);
            chk("pc4_f", pc4_f, e.pc4);
            chk("npc", npc, e.npc);
            chk("excode_f", 32'(excode_f), 32'(e.exc));
            chk("ras_count", 32'(ras_count), 32'(e.cnt));
            chk("ras_match", 32'(ras_match), 32'(e.match));
            if (e.pred_v) chk("ras_pred", ras_pred, e.pred);
        end
    end

    initial begin
        idle();
        imm16 = '0; imm26 = '0; ra_addr = '0; epc = '0; pc_d = '0;
        reset = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_pc = 32'h0000_3000;
        m_ras.delete();
        reset = 0;
        #1;
        chk("rst pc", pc_f, 32'h3000);
        chk("rst count", 32'(ras_count), 32'd0);
        chk("rst excode", 32'(excode_f), 32'd0);
        chk("rst match", 32'(ras_match), 32'd0);

        for (int i = 1; i <= 3; i++) begin
            apply();
            chk("pc4 seq", pc_f, 32'h3000 + 32'(4 * i));
        end
        apply();
        npc_op = 3'd1; imm16 = 16'hFFFC; stall = 1;
        apply();
        chk("imm16 stalled", pc_f, 32'h3010);
        stall = 0;
        apply();
        chk("imm16 back", pc_f, 32'h3000);
        stall = 1; req = 1;
        apply();
        chk("req over stall", pc_f, 32'h4180);

        idle(); npc_op = 3'd3;
        ra_addr = 32'h3002; apply();
        chk("adel misalign", 32'(excode_f), 32'd4);
        ra_addr = 32'h7000; apply();
        chk("adel high", 32'(excode_f), 32'd4);
        ra_addr = 32'h6FFC; apply();
        chk("window top", 32'(excode_f), 32'd0);
        ra_addr = 32'h2FFC; apply();
        chk("adel low", 32'(excode_f), 32'd4);
        ra_addr = 32'h3020; apply();

        idle(); npc_op = 3'd2; push_ra = 1; pc_d = 32'h3020; imm26 = 26'h0C08;
        apply();
        chk("jal count", 32'(ras_count), 32'd1);
        chk("jal pred", ras_pred, 32'h3028);
        idle(); npc_op = 3'd3; pop_ra = 1; ra_addr = 32'h3028;
        #1;
        chk("jr match", 32'(ras_match), 32'd1);
        apply();
        chk("jr count", 32'(ras_count), 32'd0);
        #1;
        chk("empty match", 32'(ras_match), 32'd0);
        apply();
        chk("empty pop", 32'(ras_count), 32'd0);

        idle(); npc_op = 3'd2; push_ra = 1;
        for (int i = 0; i < 9; i++) begin
            pc_d = 32'h3000 + 32'(8 * i);
            imm26 = 26'h0C00 + 26'(i);
            apply();
        end
        chk("full count", 32'(ras_count), 32'd8);
        chk("full pred", ras_pred, 32'h3048);
        idle(); npc_op = 3'd3; pop_ra = 1;
        for (int k = 0; k < 8; k++) begin
            ra_addr = 32'h3048 - 32'(8 * k);
            #1;
            chk("pop pred", ras_pred, 32'h3048 - 32'(8 * k));
            chk("pop match", 32'(ras_match), 32'd1);
            apply();
        end
        chk("drained", 32'(ras_count), 32'd0);

        idle(); stall = 1; npc_op = 3'd4; epc = 32'h3100;
        apply();
        chk("eret stalled", pc_f, 32'h3100);
        idle(); npc_op = 3'd2; push_ra = 1; pc_d = 32'h3000;
        apply();
        reset = 1;
        apply();
        chk("reset pc", pc_f, 32'h3000);
        chk("reset count", 32'(ras_count), 32'd0);

        for (int i = 0; i < 600; i++) begin
            reset   = ($urandom_range(0, 59) == 0);
            stall   = ($urandom_range(0, 3) == 0);
            req     = ($urandom_range(0, 11) == 0);
            npc_op  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7))
                                                   : 3'($urandom_range(0, 4));
            imm16   = 16'($urandom);
            imm26   = 26'($urandom);
            pc_d    = $urandom;
            epc     = $urandom;
            push_ra = 1'($urandom);
            pop_ra  = 1'($urandom);
            if (m_ras.size() > 0 && $urandom_range(0, 1) == 1)
                ra_addr = m_ras[$];
            else
                ra_addr = 32'h3000 + 32'($urandom_range(0, 4096)) * 4;
            apply();
        end
        idle();

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
